sc_shiftseq_ctrl: RTL and testbench
===================================

# sc_shiftseq_ctrl

Sequencer that drives the control inputs of the team's 8-bit shift register: an active-low load, a 2-bit shift selection, and the parallel data bus. One command loads an operand, then issues N single-bit left or right shifts, then pulses done. A command may also skip the load and shift the register's current contents. The block sits between a command source (switches, or the next FSM up) and the shift register, and owns that register's control inputs exclusively.

## Interface
- DATAWIDTH_BUS, 8, width of the data bus.
- DATAWIDTH_REGSHIFTER_SELECTION, 2, width of the shift-selection code.
- DATAWIDTH_COUNT, 3, width of the shift-amount field.
- SC_ShiftSeqCTRL_CLOCK_50  in  1  system clock. This is the only clock in the block.
- SC_ShiftSeqCTRL_Reset_InHigh  in  1  reset. It is synchronous and active-high.
- SC_ShiftSeqCTRL_Start_InHigh  in  1  command strobe, sampled only in IDLE.
- SC_ShiftSeqCTRL_LoadEnable_InHigh  in  1  1 = load the operand before shifting; 0 = shift the existing contents.
- SC_ShiftSeqCTRL_Direction_InHigh  in  1  1 = right shift, 0 = left shift.
- SC_ShiftSeqCTRL_Count_In  in  DATAWIDTH_COUNT  number of single-bit shifts, 0..2^DATAWIDTH_COUNT-1.
- SC_ShiftSeqCTRL_DataBUS_In  in  DATAWIDTH_BUS  operand.
- SC_ShiftSeqCTRL_Load_OutLow  out  1  drives the shift register's active-low load.
- SC_ShiftSeqCTRL_ShiftSelection_OutLow  out  DATAWIDTH_REGSHIFTER_SELECTION  shift code: 00 = hold, 01 = left, 10 = right; 11 is never driven.
- SC_ShiftSeqCTRL_DataBUS_Out  out  DATAWIDTH_BUS  operand presented to the shift register's data input.
- SC_ShiftSeqCTRL_Busy_OutHigh  out  1  a command is in progress.
- SC_ShiftSeqCTRL_Done_OutHigh  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are registered (Moore style).
- IDLE, when Start=1:
  - capture Data, Direction and Count into internal registers;
  - next state is LOAD if LoadEnable=1;
  - otherwise next state is SHIFT if Count≠0, else DONE.
- LOAD: Load_OutLow=0 and DataBUS_Out=captured operand, both for exactly one cycle. Next state is SHIFT if Count≠0, else DONE.
- SHIFT: ShiftSelection is 01 (left) or 10 (right) every cycle. The down-counter is preloaded with Count and decrements once per SHIFT cycle. Exit to DONE after exactly Count SHIFT cycles.
- DONE: Done=1 for one cycle, then return to IDLE.
- Busy=1 in LOAD, SHIFT and DONE; Busy=0 in IDLE.
- Outside LOAD, Load_OutLow=1. Outside SHIFT, ShiftSelection=00.
- DataBUS_Out holds the last captured operand and changes only on capture.
- Start outside IDLE is ignored. It is not queued.
- Input changes after the capture cycle have no effect on the command in progress.
- Reset values: state IDLE, Load_OutLow=1, ShiftSelection=00, DataBUS_Out=0, Busy=0, Done=0, counter 0, captured fields 0.
- Reset asserted mid-command takes effect at the next clock edge:
  - return to IDLE with reset values;
  - no Done pulse is issued;
  - the partial shift already applied to the register is not undone.

## Timing
- Start is sampled high at edge t in IDLE.
- With load: LOAD runs in cycle t+1. SHIFT runs in cycles t+2..t+1+N. DONE is at t+2+N. IDLE is at t+3+N.
- Without load: SHIFT runs in cycles t+1..t+N. DONE is at t+1+N.
- N=0 with load: LOAD at t+1, DONE at t+2.
- N=0 without load: DONE at t+1.
- A new Start is accepted no earlier than the first IDLE cycle after DONE.
- The shift register samples the controls at the end of each cycle. Its contents after DONE therefore equal the final result.
- Shifts are logical: zero fill, bits beyond DATAWIDTH_BUS are lost. No rotate.

## Structure
- Shared package contents:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3);
  - selection codes SEL_HOLD=2'b00, SEL_LEFT=2'b01, SEL_RIGHT=2'b10.
- One sub-module: sc_shiftseq_downcounter. It is a DATAWIDTH_COUNT-bit counter with synchronous reset, preload, decrement enable and a zero flag.
- The FSM lives in the top module as separate next-state, state-register and output-register processes.
- The bench wraps the controller together with the shift register.

## Test plan
- Reset, then idle with Start=0 for 10 cycles -> all outputs hold their reset values; Busy=0, Done=0.
- Load 0x81, left, N=3 -> Load_OutLow low at t+1; ShiftSelection=01 for t+2..t+4; Done at t+5; register = 0x08.
- Load 0xB4, right, N=2 -> ShiftSelection=10 for 2 cycles; Done at t+4; register = 0x2D. Then a no-load left shift with N=1 -> Load_OutLow stays 1; Done at t+2; register = 0x5A.
- Load 0x5A, N=0 -> one LOAD cycle, no SHIFT cycles, Done at t+2, register = 0x5A. No-load with N=0 -> Done at t+1, register unchanged.
- Start pulses during SHIFT, and Data/Count changed mid-command -> ignored; the result and cycle count match the original command.
- Load 0xFF, left, N=7; assert reset in the 3rd SHIFT cycle -> next cycle is IDLE, reset outputs, no Done. A new command afterwards completes normally.

Source files
------------

// File: rtl/sc_shiftseq_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer.
// Holds the bus/selection/count widths, the FSM state encoding and the
// shift-selection codes driven onto the shift register's select input.
package sc_shiftseq_ctrl_pkg;

    localparam int DATAWIDTH_BUS                  = 8;
    localparam int DATAWIDTH_REGSHIFTER_SELECTION = 2;
    localparam int DATAWIDTH_COUNT                = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_HOLD  = 2'b00;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  = 2'b01;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT = 2'b10;

endpackage

// File: rtl/sc_shiftseq_downcounter.sv
// Shift-amount down-counter for the sequencer.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset, clears the count
//   load       - preload value_q with load_value (has priority over dec)
//   load_value - shift amount to preload
//   dec        - decrement by one (saturates at zero)
//   value      - current count
//   zero       - high when the count is zero
module sc_shiftseq_downcounter
    import sc_shiftseq_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [DATAWIDTH_COUNT-1:0] load_value,
    input  logic                       dec,
    output logic [DATAWIDTH_COUNT-1:0] value,
    output logic                       zero
);

    logic [DATAWIDTH_COUNT-1:0] value_q;
    logic [DATAWIDTH_COUNT-1:0] value_d;

    // Decrement saturates so a stray enable at zero cannot wrap to the maximum.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - DATAWIDTH_COUNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/sc_shiftseq_ctrl.sv
// Sequencer driving the control inputs of an 8-bit shift register.
// A command optionally loads an operand, then issues N single-bit logical
// shifts left or right, then pulses done. All outputs are registered and
// follow the state the FSM is entering, so they line up with the state.
// Ports:
//   SC_ShiftSeqCTRL_CLOCK_50               - system clock
//   SC_ShiftSeqCTRL_Reset_InHigh           - synchronous active-high reset
//   SC_ShiftSeqCTRL_Start_InHigh           - command strobe (IDLE only)
//   SC_ShiftSeqCTRL_LoadEnable_InHigh      - 1 = load operand before shifting
//   SC_ShiftSeqCTRL_Direction_InHigh       - 1 = right, 0 = left
//   SC_ShiftSeqCTRL_Count_In               - number of single-bit shifts
//   SC_ShiftSeqCTRL_DataBUS_In             - operand
//   SC_ShiftSeqCTRL_Load_OutLow            - shift register load (active low)
//   SC_ShiftSeqCTRL_ShiftSelection_OutLow  - 00 hold, 01 left, 10 right
//   SC_ShiftSeqCTRL_DataBUS_Out            - captured operand
//   SC_ShiftSeqCTRL_Busy_OutHigh           - command in progress
//   SC_ShiftSeqCTRL_Done_OutHigh           - one-cycle completion pulse
module sc_shiftseq_ctrl
    import sc_shiftseq_ctrl_pkg::*;
(
    input  logic                                      SC_ShiftSeqCTRL_CLOCK_50,
    input  logic                                      SC_ShiftSeqCTRL_Reset_InHigh,
    input  logic                                      SC_ShiftSeqCTRL_Start_InHigh,
    input  logic                                      SC_ShiftSeqCTRL_LoadEnable_InHigh,
    input  logic                                      SC_ShiftSeqCTRL_Direction_InHigh,
    input  logic [DATAWIDTH_COUNT-1:0]                SC_ShiftSeqCTRL_Count_In,
    input  logic [DATAWIDTH_BUS-1:0]                  SC_ShiftSeqCTRL_DataBUS_In,
    output logic                                      SC_ShiftSeqCTRL_Load_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_ShiftSeqCTRL_ShiftSelection_OutLow,
    output logic [DATAWIDTH_BUS-1:0]                  SC_ShiftSeqCTRL_DataBUS_Out,
    output logic                                      SC_ShiftSeqCTRL_Busy_OutHigh,
    output logic                                      SC_ShiftSeqCTRL_Done_OutHigh
);

    state_t state_q, state_d;

    logic                                      dir_q, dir_d;
    logic [DATAWIDTH_BUS-1:0]                  data_q, data_d;
    logic                                      load_n_q, load_n_d;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] sel_q, sel_d;
    logic                                      busy_q, busy_d;
    logic                                      done_q, done_d;

    logic                       capture;
    logic [DATAWIDTH_COUNT-1:0] cnt_value;
    logic                       cnt_zero;

    assign capture = (state_q == IDLE) && SC_ShiftSeqCTRL_Start_InHigh;

    // The counter is preloaded on capture so LOAD can already see its zero flag.
    sc_shiftseq_downcounter u_downcounter (
        .clk        (SC_ShiftSeqCTRL_CLOCK_50),
        .rst        (SC_ShiftSeqCTRL_Reset_InHigh),
        .load       (capture),
        .load_value (SC_ShiftSeqCTRL_Count_In),
        .dec        (state_q == SHIFT),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // Next-state logic. The count of one in SHIFT means this is the last shift.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (SC_ShiftSeqCTRL_Start_InHigh) begin
                    if (SC_ShiftSeqCTRL_LoadEnable_InHigh) begin
                        state_d = LOAD;
                    end else if (SC_ShiftSeqCTRL_Count_In != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD:    state_d = cnt_zero ? DONE : SHIFT;
            SHIFT:   state_d = (cnt_value == DATAWIDTH_COUNT'(1)) ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SC_ShiftSeqCTRL_CLOCK_50) begin
        if (SC_ShiftSeqCTRL_Reset_InHigh) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from the state being entered so the registered
    // values are valid for the whole cycle spent in that state. Direction
    // is taken from the input on the capture cycle because a no-load
    // command goes straight into SHIFT.
    always_comb begin
        data_d   = capture ? SC_ShiftSeqCTRL_DataBUS_In : data_q;
        dir_d    = capture ? SC_ShiftSeqCTRL_Direction_InHigh : dir_q;
        load_n_d = (state_d != LOAD);
        sel_d    = SEL_HOLD;
        if (state_d == SHIFT) begin
            sel_d = dir_d ? SEL_RIGHT : SEL_LEFT;
        end
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge SC_ShiftSeqCTRL_CLOCK_50) begin
        if (SC_ShiftSeqCTRL_Reset_InHigh) begin
            data_q   <= '0;
            dir_q    <= 1'b0;
            load_n_q <= 1'b1;
            sel_q    <= SEL_HOLD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            data_q   <= data_d;
            dir_q    <= dir_d;
            load_n_q <= load_n_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SC_ShiftSeqCTRL_Load_OutLow           = load_n_q;
    assign SC_ShiftSeqCTRL_ShiftSelection_OutLow = sel_q;
    assign SC_ShiftSeqCTRL_DataBUS_Out           = data_q;
    assign SC_ShiftSeqCTRL_Busy_OutHigh          = busy_q;
    assign SC_ShiftSeqCTRL_Done_OutHigh          = done_q;

endmodule

// File: tb/tb_sc_shiftseq_ctrl.sv
// Bench for sc_shiftseq_ctrl wrapped together with a behavioural 8-bit
// shift register. Expected per-cycle controls come from the command timing
// (load cycle, N shift cycles, done cycle); the expected register contents
// come from plain shift arithmetic on the operand.
module tb_sc_shiftseq_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       load_en  = 1'b0;
    logic       dir      = 1'b0;
    logic [2:0] count_in = 3'd0;
    logic [7:0] data_in  = 8'h00;

    logic       load_n;
    logic [1:0] sel;
    logic [7:0] bus_out;
    logic       busy;
    logic       done;

    logic [7:0] sreg      = 8'h00;
    logic [7:0] model_reg = 8'h00;

    int vectors     = 0;
    int miscompares = 0;

    sc_shiftseq_ctrl dut (
        .SC_ShiftSeqCTRL_CLOCK_50              (clk),
        .SC_ShiftSeqCTRL_Reset_InHigh          (reset),
        .SC_ShiftSeqCTRL_Start_InHigh          (start),
        .SC_ShiftSeqCTRL_LoadEnable_InHigh     (load_en),
        .SC_ShiftSeqCTRL_Direction_InHigh      (dir),
        .SC_ShiftSeqCTRL_Count_In              (count_in),
        .SC_ShiftSeqCTRL_DataBUS_In            (data_in),
        .SC_ShiftSeqCTRL_Load_OutLow           (load_n),
        .SC_ShiftSeqCTRL_ShiftSelection_OutLow (sel),
        .SC_ShiftSeqCTRL_DataBUS_Out           (bus_out),
        .SC_ShiftSeqCTRL_Busy_OutHigh          (busy),
        .SC_ShiftSeqCTRL_Done_OutHigh          (done)
    );

    always #10 clk = ~clk;

    // The team's shift register: samples the controls at every rising edge.
    always @(posedge clk) begin
        if (load_n == 1'b0) begin
            sreg <= bus_out;
        end else if (sel == 2'b01) begin
            sreg <= sreg << 1;
        end else if (sel == 2'b10) begin
            sreg <= sreg >> 1;
        end
    end

    function automatic logic [7:0] shifted(input logic [7:0] v, input bit right, input int n);
        logic [7:0] r;
        r = right ? (v >> n) : (v << n);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " load_n"}, 32'(load_n), 32'd1);
        checkOutput({tag, " sel"},    32'(sel),    32'd0);
        checkOutput({tag, " bus"},    32'(bus_out), 32'd0);
        checkOutput({tag, " busy"},   32'(busy),   32'd0);
        checkOutput({tag, " done"},   32'(done),   32'd0);
    endtask

    // Issues one command in the current (IDLE) cycle and checks every cycle
    // through the first IDLE cycle afterwards. rst_k != 0 asserts reset
    // during cycle rst_k after the start edge; disturb scrambles inputs and
    // pulses start while the command runs.
    task automatic applyStimulus(input bit ld, input bit right, input int n,
                                 input logic [7:0] operand, input bit disturb, input int rst_k);
        int         off;
        int         done_k;
        int         shifts;
        logic [7:0] base;
        logic [1:0] exp_sel;
        off    = ld ? 1 : 0;
        done_k = off + n + 1;
        base   = ld ? operand : model_reg;
        start    = 1'b1;
        load_en  = ld;
        dir      = right;
        count_in = 3'(n);
        data_in  = operand;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (rst_k != 0 && k == rst_k + 1) begin
                shifts = rst_k - off;
                if (shifts < 0) shifts = 0;
                if (shifts > n) shifts = n;
                model_reg = shifted(base, right, shifts);
                checkResetOutputs($sformatf("midrst k=%0d", k));
                checkOutput("midrst reg", 32'(sreg), 32'(model_reg));
                reset = 1'b0;
                return;
            end
            exp_sel = (k > off && k <= off + n) ? (right ? 2'b10 : 2'b01) : 2'b00;
            checkOutput($sformatf("load_n k=%0d", k), 32'(load_n), 32'(!(ld && k == 1)));
            checkOutput($sformatf("sel k=%0d", k),    32'(sel),    32'(exp_sel));
            checkOutput($sformatf("done k=%0d", k),   32'(done),   32'(k == done_k));
            checkOutput($sformatf("busy k=%0d", k),   32'(busy),   32'(k <= done_k));
            checkOutput($sformatf("bus k=%0d", k),    32'(bus_out), 32'(operand));
            if (k == done_k + 1) begin
                model_reg = shifted(base, right, n);
                checkOutput("result reg", 32'(sreg), 32'(model_reg));
            end
            start = 1'b0;
            if (disturb) begin
                data_in  = 8'($urandom);
                count_in = 3'($urandom);
                dir      = 1'($urandom);
                load_en  = 1'($urandom);
                if (k > off && k <= off + n) begin
                    start = 1'($urandom_range(0, 1));
                end
            end
            if (k == rst_k) begin
                reset = 1'b1;
            end
            if (k <= done_k) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkResetOutputs($sformatf("idle i=%0d", i));
            @(posedge clk);
            #1;
        end
        checkOutput("idle reg", 32'(sreg), 32'h00);

        applyStimulus(1'b1, 1'b0, 3, 8'h81, 1'b0, 0);
        checkOutput("plan1 reg", 32'(sreg), 32'h08);
        applyStimulus(1'b1, 1'b1, 2, 8'hB4, 1'b0, 0);
        checkOutput("plan2 reg", 32'(sreg), 32'h2D);
        applyStimulus(1'b0, 1'b0, 1, 8'h00, 1'b0, 0);
        checkOutput("plan3 reg", 32'(sreg), 32'h5A);
        applyStimulus(1'b1, 1'b0, 0, 8'h5A, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 0, 8'h33, 1'b0, 0);
        checkOutput("plan4 reg", 32'(sreg), 32'h5A);

        applyStimulus(1'b1, 1'b1, 5, 8'hC3, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 4, 8'h11, 1'b1, 0);

        applyStimulus(1'b1, 1'b0, 7, 8'hFF, 1'b0, 4);
        checkOutput("plan6 partial reg", 32'(sreg), 32'hF8);
        applyStimulus(1'b0, 1'b1, 2, 8'h00, 1'b0, 0);
        checkOutput("plan6 after reg", 32'(sreg), 32'h3E);

        for (int r = 0; r < 30; r++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), 8'($urandom),
                          1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
